// File: rtl/seq_div_iter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_div_iter_ctrl
// Purpose  : Iterative unsigned restoring divider for the mantissa divide
//            path. It retires 4 quotient bits per clock and uses a
//            start/busy/done handshake. The result is held until the next
//            operation is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module seq_div_iter_ctrl #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int ITER  = WIDTH / 4;
  localparam int CNT_W = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] n;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] step_n;
  logic [WIDTH:0]   step_r;
  logic [WIDTH-1:0] step_q;

  // Four chained restoring steps. The partial remainder is one bit wider
  // than the operands so the left shift cannot lose its top bit.
  always_comb begin
    step_n = n;
    step_r = r;
    step_q = q;
    for (int i = 0; i < 4; i++) begin
      step_r = {step_r[WIDTH-1:0], step_n[WIDTH-1]};
      step_n = step_n << 1;
      if (step_r >= {1'b0, d}) begin
        step_r = step_r - {1'b0, d};
        step_q = {step_q[WIDTH-2:0], 1'b1};
      end else begin
        step_q = {step_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Next-state decode. A start is honoured only when no operation is in flight.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = (cnt == CNT_W'(ITER - 1));
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (divisor == '0) ? ST_DONE : ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, datapath and result registers. Results move only on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      n           <= '0;
      r           <= '0;
      d           <= '0;
      q           <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      if (accept) begin
        n   <= dividend;
        d   <= divisor;
        r   <= '0;
        q   <= '0;
        cnt <= '0;
        // A zero divisor completes immediately with a saturated quotient.
        if (divisor == '0) begin
          done        <= 1'b1;
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end
      end else if (state == ST_RUN) begin
        n   <= step_n;
        r   <= step_r;
        q   <= step_q;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          done        <= 1'b1;
          quotient    <= step_q;
          remainder   <= step_r[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

  // busy comes straight from the state register, so start cannot reach it.
  assign busy = (state == ST_RUN);

endmodule
`default_nettype wire
